// File: rtl/ris_frame_unpacker_if.sv
// ris_frame_unpacker_if
//   Groups the signals between the UART byte source, the frame unpacker and
//   the per-element state decoders.
//   rx_data/rx_valid : received byte and its one-cycle qualifier
//   state_addr       : committed 2-bit state number per element (decoder Address)
//   start            : one-cycle decode strobe to all decoders
//   frame_ok         : one-cycle pulse when a frame is committed
//   frame_err        : one-cycle pulse on checksum mismatch or timeout
//   busy             : unpacker FSM is not idle
//   Modports: master drives the byte stream, slave is the unpacker.
interface ris_frame_unpacker_if #(
  parameter int NUM_ELEM = 16
) ();
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [2*NUM_ELEM-1:0] state_addr;
  logic                  start;
  logic                  frame_ok;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output rx_data, rx_valid,
    input  state_addr, start, frame_ok, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output state_addr, start, frame_ok, frame_err, busy
  );
endinterface

// File: rtl/ris_frame_unpacker.sv
// ris_frame_unpacker
//   Locates RIS control frames in the UART byte stream, unpacks the 2-bit
//   per-element state numbers into a shadow bank and commits the bank to the
//   decoder addresses atomically, followed by a one-cycle start strobe.
//   Frame: HEADER, NUM_ELEM/4 payload bytes (first byte = elements 0..3,
//   least significant), then an XOR checksum byte when RIS_CHECKSUM_EN is
//   defined. Without RIS_CHECKSUM_EN the checksum byte is absent and
//   frame_err reports only timeouts.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - ris_frame_unpacker_if.slave (rx_data, rx_valid in;
//            state_addr, start, frame_ok, frame_err, busy out)
//   Parameters: NUM_ELEM (multiple of 4, >= 4), HEADER, TIMEOUT_CYC.
module ris_frame_unpacker #(
  parameter int         NUM_ELEM    = 16,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  ris_frame_unpacker_if.slave   bus
);

  localparam int NPB   = NUM_ELEM / 4;
  localparam int CNT_W = (NPB > 1) ? $clog2(NPB) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPB - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PAYLOAD = 3'd1;
`ifdef RIS_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd2;
`endif
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_STROBE  = 3'd4;

  logic [2:0]            state;
  logic [CNT_W-1:0]      byte_cnt;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [2*NUM_ELEM-1:0] shadow;
  logic [2*NUM_ELEM-1:0] state_addr_q;
  logic                  start_q;
  logic                  frame_ok_q;
  logic                  frame_err_q;
`ifdef RIS_CHECKSUM_EN
  logic [7:0]            acc;
`endif

  assign bus.state_addr = state_addr_q;
  assign bus.start      = start_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      shadow       <= '0;
      state_addr_q <= '0;
      start_q      <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef RIS_CHECKSUM_EN
      acc          <= '0;
`endif
    end else begin
      // Status outputs are single-cycle pulses unless set below.
      start_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.rx_valid && bus.rx_data == HEADER) begin
            state    <= S_PAYLOAD;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
`ifdef RIS_CHECKSUM_EN
            acc      <= '0;
`endif
          end
        end

        // Header bytes inside the payload are plain data: no resync.
        S_PAYLOAD: begin
          if (tmo_cnt == TMO_MAX) begin
            state       <= S_IDLE;
            frame_err_q <= 1'b1;
          end else if (bus.rx_valid) begin
            shadow[byte_cnt*8 +: 8] <= bus.rx_data;
            byte_cnt                <= byte_cnt + 1'b1;
            tmo_cnt                 <= '0;
`ifdef RIS_CHECKSUM_EN
            acc                     <= acc ^ bus.rx_data;
            if (byte_cnt == LAST_IDX) state <= S_CHECK;
`else
            if (byte_cnt == LAST_IDX) state <= S_COMMIT;
`endif
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

`ifdef RIS_CHECKSUM_EN
        S_CHECK: begin
          if (tmo_cnt == TMO_MAX) begin
            state       <= S_IDLE;
            frame_err_q <= 1'b1;
          end else if (bus.rx_valid) begin
            tmo_cnt <= '0;
            if (bus.rx_data == acc) begin
              state <= S_COMMIT;
            end else begin
              state       <= S_IDLE;
              frame_err_q <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
`endif

        // Addresses change one full cycle ahead of the decode strobe.
        S_COMMIT: begin
          state_addr_q <= shadow;
          frame_ok_q   <= 1'b1;
          state        <= S_STROBE;
        end

        S_STROBE: begin
          start_q <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ris_frame_unpacker.sv
module tb_ris_frame_unpacker;

  localparam int         NUM_ELEM = 8;
  localparam int         TMO      = 100;
  localparam logic [7:0] HDR      = 8'hA5;
`ifdef RIS_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_start;
  int   n_ok;
  int   n_err;

  ris_frame_unpacker_if #(.NUM_ELEM(NUM_ELEM)) bus ();

  ris_frame_unpacker #(
    .NUM_ELEM    (NUM_ELEM),
    .HEADER      (HDR),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters used to prove that failed frames never strobe.
  always @(posedge clk) begin
    if (bus.start)     n_start <= n_start + 1;
    if (bus.frame_ok)  n_ok    <= n_ok + 1;
    if (bus.frame_err) n_err   <= n_err + 1;
  end

  // Returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends header, payload (first byte = low byte) and, when present, the
  // checksum XOR corrupt. Returns in cycle T+1.
  task automatic send_frame(input logic [15:0] payload, input logic [7:0] corrupt);
    logic [7:0] cs;
    cs = payload[7:0] ^ payload[15:8] ^ corrupt;
    send_byte(HDR);
    send_byte(payload[7:0]);
    send_byte(payload[15:8]);
    if (CSUM) send_byte(cs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    n_start = 0; n_ok = 0; n_err = 0;
    idle(3);
    rst = 1'b0;
    idle(1);
    total++; if (bus.state_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", bus.state_addr); end
    total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", bus.start); end
    total++; if (bus.frame_ok !== 1'b0) begin bad++; $display("FAIL reset_ok got=%b want=0", bus.frame_ok); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.frame_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    idle(5);
    total++; if (n_start !== 0) begin bad++; $display("FAIL reset_nostart got=%0d want=0", n_start); end
  endtask

  task automatic test_good_frame();
    logic [15:0] want;
    int s0;
    want = CSUM ? 16'hE41B : 16'h1234;
    s0 = n_start;
    send_frame(want, 8'h00);
    // T+1
    total++; if (bus.state_addr !== 16'h0000) begin bad++; $display("FAIL good_t1_addr got=%h want=0000", bus.state_addr); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL good_t1_busy got=%b want=1", bus.busy); end
    total++; if (bus.frame_ok !== 1'b0) begin bad++; $display("FAIL good_t1_ok got=%b want=0", bus.frame_ok); end
    idle(1); // T+2
    total++; if (bus.state_addr !== want) begin bad++; $display("FAIL good_t2_addr got=%h want=%h", bus.state_addr, want); end
    total++; if (bus.frame_ok !== 1'b1) begin bad++; $display("FAIL good_t2_ok got=%b want=1", bus.frame_ok); end
    total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL good_t2_start got=%b want=0", bus.start); end
    idle(1); // T+3
    total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL good_t3_start got=%b want=1", bus.start); end
    total++; if (bus.frame_ok !== 1'b0) begin bad++; $display("FAIL good_t3_ok got=%b want=0", bus.frame_ok); end
    idle(1); // T+4
    total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL good_t4_start got=%b want=0", bus.start); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL good_t4_busy got=%b want=0", bus.busy); end
    total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL good_nstart got=%0d want=1", n_start - s0); end
  endtask

`ifdef RIS_CHECKSUM_EN
  task automatic test_bad_checksum();
    int s0;
    int e0;
    s0 = n_start;
    e0 = n_err;
    send_byte(HDR); send_byte(8'h1B); send_byte(8'hE4); send_byte(8'h00);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL badcs_err got=%b want=1", bus.frame_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL badcs_busy got=%b want=0", bus.busy); end
    idle(4);
    total++; if (bus.state_addr !== 16'hE41B) begin bad++; $display("FAIL badcs_addr got=%h want=e41b", bus.state_addr); end
    total++; if (n_start - s0 !== 0) begin bad++; $display("FAIL badcs_nostart got=%0d want=0", n_start - s0); end
    total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL badcs_nerr got=%0d want=1", n_err - e0); end
  endtask
`endif

  task automatic test_junk();
    send_byte(8'h00);
    send_byte(8'h3C);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL junk_busy got=%b want=0", bus.busy); end
    send_frame(16'hAA55, 8'h00);
    idle(1);
    total++; if (bus.state_addr !== 16'hAA55) begin bad++; $display("FAIL junk_addr got=%h want=aa55", bus.state_addr); end
    idle(3);
  endtask

  task automatic test_timeout();
    int seen;
    int s0;
    seen = -1;
    s0 = n_start;
    send_byte(HDR);
    send_byte(8'h12);
    for (int i = 1; i <= 3 * TMO; i++) begin
      @(posedge clk); #1;
      if (bus.frame_err === 1'b1) begin
        seen = i;
        break;
      end
    end
    total++; if (seen !== TMO + 1) begin bad++; $display("FAIL timeout_cycle got=%0d want=%0d", seen, TMO + 1); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b want=0", bus.busy); end
    idle(1);
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%b want=0", bus.frame_err); end
    total++; if (bus.state_addr !== 16'hAA55) begin bad++; $display("FAIL timeout_addr got=%h want=aa55", bus.state_addr); end
    total++; if (n_start - s0 !== 0) begin bad++; $display("FAIL timeout_nostart got=%0d want=0", n_start - s0); end
    send_frame(16'h0000, 8'h00);
    idle(1);
    total++; if (bus.state_addr !== 16'h0000 || bus.frame_ok !== 1'b1) begin bad++; $display("FAIL timeout_next got=%h/%b want=0000/1", bus.state_addr, bus.frame_ok); end
    idle(3);
  endtask

  task automatic test_random();
    logic [15:0] exp_addr;
    logic [15:0] pl;
    logic [7:0]  corrupt;
    logic [7:0]  junk;
    bit          fail;
    exp_addr = bus.state_addr === 16'h0000 ? 16'h0000 : 16'hxxxx;
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        junk = 8'($urandom);
        if (junk == HDR) junk = 8'h00;
        send_byte(junk);
      end
      pl      = 16'($urandom);
      corrupt = 8'h00;
      if (CSUM && $urandom_range(0, 3) == 0) corrupt = 8'($urandom_range(1, 255));
      fail = (corrupt != 8'h00);
      send_frame(pl, corrupt);
      if (!fail) exp_addr = pl;
      total++; if (bus.frame_err !== fail) begin bad++; $display("FAIL rnd%0d_err got=%b want=%b", f, bus.frame_err, fail); end
      idle(1);
      total++; if (bus.state_addr !== exp_addr) begin bad++; $display("FAIL rnd%0d_addr got=%h want=%h", f, bus.state_addr, exp_addr); end
      total++; if (bus.frame_ok !== !fail) begin bad++; $display("FAIL rnd%0d_ok got=%b want=%b", f, bus.frame_ok, !fail); end
      idle(1);
      total++; if (bus.start !== !fail) begin bad++; $display("FAIL rnd%0d_start got=%b want=%b", f, bus.start, !fail); end
      idle($urandom_range(1, 3));
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    send_frame(16'h5A3C, 8'h00);
    idle(4);
    s0 = n_start;
    send_byte(HDR);
    send_byte(8'h77);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.state_addr !== 16'h0000) begin bad++; $display("FAIL rstmid_addr got=%h want=0000", bus.state_addr); end
    total++; if (bus.busy !== 1'b0 || bus.start !== 1'b0 || bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_outs got=%b%b%b%b want=0000", bus.busy, bus.start, bus.frame_ok, bus.frame_err);
    end
    rst = 1'b0;
    send_byte(8'h11);
    send_byte(8'h66);
    idle(4);
    total++; if (bus.state_addr !== 16'h0000 || bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_ignore got=%h/%b want=0000/0", bus.state_addr, bus.busy); end
    total++; if (n_start - s0 !== 0) begin bad++; $display("FAIL rstmid_nostart got=%0d want=0", n_start - s0); end
    send_frame(16'hC381, 8'h00);
    idle(1);
    total++; if (bus.state_addr !== 16'hC381) begin bad++; $display("FAIL rstmid_after got=%h want=c381", bus.state_addr); end
    idle(3);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_good_frame();
`ifdef RIS_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_junk();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ris_frame_unpacker.md
# ris_frame_unpacker

Receives the byte stream from the UART receiver, locates RIS control frames, unpacks the 2-bit per-element state numbers and drives the address inputs and `start` strobe of the per-element state decoders, which map each number to its GPIO/DPS drive pattern. Frames are assembled in a shadow bank and committed atomically, so decoder addresses never change mid-frame. Sits between the RS232 RX block and the array of per-element decoders.

## Interface
- `NUM_ELEM`, 16: number of RIS elements; must be a multiple of 4, minimum 4.
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT_CYC`, 50000: maximum idle cycles between bytes inside a frame.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` = 1.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `state_addr`  out  2*NUM_ELEM  committed state numbers; element i on bits [2i+1:2i]; feeds decoder `Address`.
- `start`  out  1  one-cycle decode strobe to all decoders.
- `frame_ok`  out  1  one-cycle pulse when a frame is committed.
- `frame_err`  out  1  one-cycle pulse on checksum mismatch or timeout.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Frame format: `HEADER`, then NPB = NUM_ELEM/4 payload bytes, then one checksum byte (XOR of all payload bytes; see Configuration).
- Payload byte k holds elements 4k..4k+3; element 4k+j is on bits [2j+1:2j]. This makes `state_addr` the payload bytes concatenated, first byte least significant.
- FSM states:
  - IDLE: bytes other than `HEADER` are discarded. `HEADER` -> PAYLOAD; clears byte counter, XOR accumulator, and timeout counter.
  - PAYLOAD: each byte is written to shadow slot [counter] and XORed into the accumulator. After byte NPB-1: -> CHECK. A byte equal to `HEADER` is treated as data; there is no resync.
  - CHECK: the next byte is compared against the accumulator. Match -> COMMIT. Mismatch -> IDLE with `frame_err`.
  - COMMIT: `state_addr` <= shadow and `frame_ok` <= 1, unconditionally. Then -> STROBE.
  - STROBE: `start` <= 1, unconditionally. Then -> IDLE.
- Timeout: in PAYLOAD or CHECK, a counter increments on every cycle without `rx_valid` and clears on each accepted byte. When it reaches `TIMEOUT_CYC`: -> IDLE with `frame_err`. The shadow bank is abandoned and `state_addr` is unchanged.
- `rx_valid` during COMMIT or STROBE is ignored. UART byte spacing far exceeds two cycles.
- A failed frame never alters `state_addr` and never pulses `start`.

## Timing
- Reset values: FSM IDLE; `state_addr` = 0 (every element at state 0); `start`, `frame_ok`, `frame_err`, `busy` = 0; shadow bank, counters and accumulator = 0. No `start` pulse is issued after reset.
- Reset asserted mid-frame: the frame is discarded and all outputs return to reset values on the next edge.
- The last frame byte is accepted in cycle T.
  - T+1: FSM in COMMIT.
  - T+2: new `state_addr` visible; `frame_ok` = 1.
  - T+3: `start` = 1, one cycle only.
- `state_addr` is stable for at least one full cycle before `start` rises, and is held until the next commit.
- `frame_err` is high in cycle T+1 for a checksum failure, and in the cycle after the timeout threshold is reached.
- `busy` is high from the cycle after header acceptance through the STROBE cycle.

## Configuration
- `RIS_CHECKSUM_EN` defined: CHECK state and XOR accumulator are present; behaviour is as above.
- `RIS_CHECKSUM_EN` undefined:
  - No checksum byte; PAYLOAD goes directly to COMMIT after byte NPB-1.
  - Commit latency is unchanged relative to the last byte (`state_addr` at T+2, `start` at T+3).
  - `frame_err` is raised only by timeout.

## Test plan
All scenarios use NUM_ELEM=8 and TIMEOUT_CYC=100, with checksum enabled unless stated.
- Good frame A5,1B,E4,FF -> `state_addr`=16'hE41B at T+2, `frame_ok` at T+2, single `start` at T+3.
- Bad checksum A5,1B,E4,00 after the good frame -> `frame_err` at T+1; `state_addr` stays 16'hE41B; no `start`.
- Junk 00,3C before A5,55,AA,FF -> junk ignored; `state_addr`=16'hAA55.
- A5,12 then 100 idle cycles -> `frame_err` pulse, `busy` falls; following A5,00,00,00 commits `state_addr`=16'h0000.
- `rst` pulsed after the second byte of a frame -> all outputs are zero the next cycle; the remaining bytes are ignored until a new A5.
- Macro undefined, A5,34,12 -> `state_addr`=16'h1234 at T+2, `start` at T+3.
